// File: rtl/minmax_window_stats.sv
// minmax_window_stats
// Windowed amplitude statistics behind a registered running min/max tracker.
// The block drives the tracker's reset to frame fixed-length sample windows.
// At the end of each window it captures xmin/xmax and produces three results:
// peak-to-peak, a floored midpoint (DC offset) and a full-scale clip flag.
// The results are held behind a valid/ready handshake.
//
// Ports:
//   clk, reset    single clock; synchronous active-high reset
//   enable        run windows while high; low aborts the current window
//   wlen          window length in samples (0 behaves as 1), applied per window
//   xmin, xmax    signed running extremes from the tracker
//   mm_reset      tracker reset, decoded from the registered state
//   ptp           xmax - xmin of the last window (unsigned, width+1 bits)
//   mid           floor((xmax + xmin) / 2) of the last window (signed)
//   clip          last window touched a full-scale code
//   valid, ready  result handshake
//   overrun       sticky: an unread result was overwritten
module minmax_window_stats #(
  parameter int width = 14,
  parameter int cw    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [cw-1:0]           wlen,
  input  logic signed [width-1:0] xmin,
  input  logic signed [width-1:0] xmax,
  output logic                    mm_reset,
  output logic [width:0]          ptp,
  output logic signed [width-1:0] mid,
  output logic                    clip,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, LATCH} state_t;

  localparam logic signed [width-1:0] FS_POS = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [width-1:0] FS_NEG = {1'b1, {(width-1){1'b0}}};

  // xmax >= xmin always holds, so the width+1 bit difference never overflows.
  function automatic logic [width:0] calc_ptp(input logic signed [width-1:0] hi,
                                              input logic signed [width-1:0] lo);
    logic [width:0] d;
    d = {hi[width-1], hi} - {lo[width-1], lo};
    return d;
  endfunction

  // Arithmetic shift of the width+1 bit sum floors toward minus infinity.
  function automatic logic signed [width-1:0] calc_mid(input logic signed [width-1:0] hi,
                                                       input logic signed [width-1:0] lo);
    logic signed [width:0] s;
    s = $signed({hi[width-1], hi}) + $signed({lo[width-1], lo});
    s = s >>> 1;
    return $signed(s[width-1:0]);
  endfunction

  function automatic logic calc_clip(input logic signed [width-1:0] hi,
                                     input logic signed [width-1:0] lo);
    return (hi == FS_POS) || (lo == FS_NEG);
  endfunction

  function automatic logic [cw-1:0] eff_len(input logic [cw-1:0] l);
    return (l == '0) ? cw'(1) : l;
  endfunction

  state_t                  state_q, state_d;
  logic [cw-1:0]           cnt_q, cnt_d;
  logic [cw-1:0]           len_q, len_d;
  logic [width:0]          ptp_q, ptp_d;
  logic signed [width-1:0] mid_q, mid_d;
  logic                    clip_q, clip_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    load;

  // Window sequencing, result capture and handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ptp_d     = ptp_q;
    mid_d     = mid_q;
    clip_d    = clip_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = CLEAR;
      end
      CLEAR: begin
        len_d   = eff_len(wlen);
        cnt_d   = cw'(1);
        state_d = ACCUM;
      end
      ACCUM: begin
        if (cnt_q == len_q) state_d = LATCH;
        else                cnt_d   = cnt_q + cw'(1);
      end
      LATCH: begin
        len_d   = eff_len(wlen);
        cnt_d   = cw'(1);
        state_d = ACCUM;
        load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable abandons whatever window is in flight, including its load.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      load    = 1'b0;
    end

    if (load) begin
      ptp_d   = calc_ptp(xmax, xmin);
      mid_d   = calc_mid(xmax, xmin);
      clip_d  = calc_clip(xmax, xmin);
      valid_d = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= cw'(1);
      ptp_q     <= '0;
      mid_q     <= '0;
      clip_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ptp_q     <= ptp_d;
      mid_q     <= mid_d;
      clip_q    <= clip_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Pure decode of the registered state keeps the tracker reset glitch-free.
  assign mm_reset = (state_q != ACCUM);
  assign ptp      = ptp_q;
  assign mid      = mid_q;
  assign clip     = clip_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_minmax_window_stats.sv
module tb_minmax_window_stats;

  localparam int W    = 14;
  localparam int CW   = 16;
  localparam logic signed [W-1:0] DEAD = 14'sd8191;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [CW-1:0]       wlen;
  logic signed [W-1:0] xin;
  logic signed [W-1:0] xmin;
  logic signed [W-1:0] xmax;
  logic                mm_reset;
  logic [W:0]          ptp;
  logic signed [W-1:0] mid;
  logic                clip;
  logic                valid;
  logic                ready;
  logic                overrun;

  typedef struct {
    int ptp;
    int mid;
    int clip;
    int cyc;
  } exp_t;

  exp_t                exp_q[$];
  logic signed [W-1:0] sq[$];
  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  minmax_window_stats #(.width(W), .cw(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .wlen     (wlen),
    .xmin     (xmin),
    .xmax     (xmax),
    .mm_reset (mm_reset),
    .ptp      (ptp),
    .mid      (mid),
    .clip     (clip),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun)
  );

  // Behavioural registered min/max tracker; reset parks it at neutral extremes.
  always_ff @(posedge clk) begin
    if (mm_reset) begin
      xmin <= 14'sd8191;
      xmax <= -14'sd8192;
    end else begin
      if (xin < xmin) xmin <= xin;
      if (xin > xmax) xmax <= xin;
    end
  end

  // Sample feeder: window samples go out only in ACCUM cycles, DEAD otherwise.
  always @(posedge clk) begin
    #1;
    if (!mm_reset) xin = (sq.size() > 0) ? sq.pop_front() : '0;
    else           xin = DEAD;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ptp", int'(ptp), e.ptp);
        check("mid", int'(mid), e.mid);
        check("clip", int'(clip), e.clip);
        if (e.cyc >= 0) check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic win(input int n, input int a, input int b, input int c, input int d);
    int s[4];
    s = '{a, b, c, d};
    for (int i = 0; i < n; i++) sq.push_back(W'(s[i]));
  endtask

  task automatic expect_res(input int p, input int m, input int cl, input int at);
    exp_t e;
    e.ptp = p; e.mid = m; e.clip = cl; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Wait for the scoreboard to drain, then drop enable before another load.
  task automatic drain_and_stop(input int budget);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    enable = 1'b0;
    tick(2);
    sq.delete();
  endtask

  initial begin
    int k;
    reset = 1'b1; enable = 1'b0; ready = 1'b0; wlen = 16'd4; xin = DEAD;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_mm_reset", int'(mm_reset), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_ptp", int'(ptp), 0);
    check("rst_mid", int'(mid), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_overrun", int'(overrun), 0);

    // Three back-to-back windows of 4 samples, consumer always ready.
    ready = 1'b1;
    k = cyc;
    win(4, -5, 100, -300, 20);    expect_res(400, -100, 0, k + 7);
    win(4, -3, 0, 0, 0);          expect_res(3, -2, 0, k + 12);
    win(4, 8191, -8192, 5, 7);    expect_res(16383, -1, 1, k + 17);
    enable = 1'b1;
    drain_and_stop(60);

    // Stalled consumer across two windows: second result overwrites the first.
    ready = 1'b0;
    k = cyc;
    win(4, 1, 2, 3, 4);
    win(4, -10, -20, 10, 20);
    expect_res(40, 0, 0, -1);
    enable = 1'b1;
    tick(8);
    check("stall1_valid", int'(valid), 1);
    check("stall1_ptp", int'(ptp), 3);
    check("stall1_mid", int'(mid), 2);
    check("stall1_overrun", int'(overrun), 0);
    tick(5);
    enable = 1'b0;
    check("stall2_valid", int'(valid), 1);
    check("stall2_ptp", int'(ptp), 40);
    check("stall2_overrun", int'(overrun), 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("accept_valid", int'(valid), 0);
    check("accept_overrun", int'(overrun), 1);
    tick(4);
    check("idle_valid", int'(valid), 0);
    sq.delete();

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst2_overrun", int'(overrun), 0);
    check("rst2_ptp", int'(ptp), 0);

    // Enable dropped at count 2 of 4, then a full window after re-enable.
    ready = 1'b1;
    wlen = 16'd4;
    win(4, 50, 60, 70, 80);
    enable = 1'b1;
    tick(3);
    check("abort_mm_reset_accum", int'(mm_reset), 0);
    enable = 1'b0;
    tick(1);
    check("abort_mm_reset", int'(mm_reset), 1);
    tick(8);
    check("abort_valid", int'(valid), 0);
    sq.delete();
    k = cyc;
    win(4, 7, -7, 3, -1);         expect_res(14, 0, 0, k + 7);
    enable = 1'b1;
    drain_and_stop(40);

    // wlen change mid-window applies to the following window.
    k = cyc;
    wlen = 16'd4;
    win(4, 10, 20, 30, 40);       expect_res(30, 25, 0, k + 7);
    win(2, -1, -2, 0, 0);         expect_res(1, -2, 0, k + 10);
    win(2, 100, -100, 0, 0);      expect_res(200, 0, 0, k + 13);
    enable = 1'b1;
    tick(3);
    wlen = 16'd2;
    drain_and_stop(40);

    // wlen = 0 behaves as a 1-sample window with period 2.
    k = cyc;
    wlen = 16'd0;
    win(1, 5, 0, 0, 0);           expect_res(0, 5, 0, k + 4);
    win(1, -6, 0, 0, 0);          expect_res(0, -6, 0, k + 6);
    win(1, 7, 0, 0, 0);           expect_res(0, 7, 0, k + 8);
    enable = 1'b1;
    drain_and_stop(40);

    tick(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
